// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle control unit: states, mux selects, ALU ops, opcodes.
package ctrl_pkg;

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECUTER = 4'd6;
  localparam logic [3:0] S_EXECUTEI = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BEQ      = 4'd9;
  localparam logic [3:0] S_JAL      = 4'd10;

  typedef enum logic [3:0] {
    FETCH    = S_FETCH,
    DECODE   = S_DECODE,
    MEMADR   = S_MEMADR,
    MEMREAD  = S_MEMREAD,
    MEMWB    = S_MEMWB,
    MEMWRITE = S_MEMWRITE,
    EXECUTER = S_EXECUTER,
    EXECUTEI = S_EXECUTEI,
    ALUWB    = S_ALUWB,
    BEQ      = S_BEQ,
    JAL      = S_JAL
  } state_t;

  // ALU operation codes, also decoded by the datapath ALU
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_REGA  = 2'b10;

  localparam logic [1:0] SRCB_REGB = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_BRNCH = 7'b1100011;

endpackage

// File: rtl/alu_decoder.sv
// Maps the FSM's ALUOp plus instruction fields onto the ALU operation code.
module alu_decoder
  import ctrl_pkg::*;
(
  input  logic [1:0] ALUOp,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       op5,
  output logic [2:0] ALU_control
);

  always_comb begin
    ALU_control = ALU_ADD;
    case (ALUOp)
      ALUOP_SUB: ALU_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // only R-type (op5=1) distinguishes sub from add; addi never subtracts
          3'b000:  ALU_control = (funct7b5 & op5) ? ALU_SUB : ALU_ADD;
          3'b010:  ALU_control = ALU_SLT;
          3'b110:  ALU_control = ALU_OR;
          3'b111:  ALU_control = ALU_AND;
          default: ALU_control = ALU_ADD;
        endcase
      end
      default: ALU_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Multicycle Moore control FSM with PCWrite/ImmSrc logic.
// Optional macro CTRL_BNE_EN: branch state also handles bne via funct3.
//
// state    | meaning
// FETCH    | load IR, PC <= PC+4
// DECODE   | read regs, compute branch target
// MEMADR   | compute load/store address
// MEMREAD  | read data memory
// MEMWB    | write loaded data to register file
// MEMWRITE | write store data to memory
// EXECUTER | register-register ALU op
// EXECUTEI | register-immediate ALU op
// ALUWB    | write ALU result to register file
// BEQ      | compare operands, conditionally update PC
// JAL      | PC <= target, compute return address
module control_unit
  import ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALU_control
);

  state_t     state, state_next;
  logic [1:0] alu_op;
  logic       pc_update, branch, taken;
  logic       mem_write_s, ir_write_s, reg_write_s;

  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= state_next;
  end

  always_comb begin
    state_next = FETCH;
    case (state)
      FETCH:  state_next = DECODE;
      DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: state_next = MEMADR;
          OP_RTYPE:          state_next = EXECUTER;
          OP_ITYPE:          state_next = EXECUTEI;
          OP_JAL:            state_next = JAL;
          OP_BRNCH:          state_next = BEQ;
          default:           state_next = FETCH;
        endcase
      end
      MEMADR:   state_next = op[5] ? MEMWRITE : MEMREAD;
      MEMREAD:  state_next = MEMWB;
      EXECUTER,
      EXECUTEI,
      JAL:      state_next = ALUWB;
      default:  state_next = FETCH;
    endcase
  end

  // Reset overrides the decoded state so outputs look like FETCH minus the write enables
  always_comb begin
    pc_update   = 1'b0;
    branch      = 1'b0;
    AdrSrc      = 1'b0;
    mem_write_s = 1'b0;
    ir_write_s  = 1'b0;
    reg_write_s = 1'b0;
    ResultSrc   = RES_ALUOUT;
    ALUSrcA     = SRCA_PC;
    ALUSrcB     = SRCB_REGB;
    alu_op      = ALUOP_ADD;
    if (reset) begin
      ALUSrcB   = SRCB_FOUR;
      ResultSrc = RES_ALURESULT;
    end else begin
      case (state)
        FETCH: begin
          ir_write_s = 1'b1;
          ALUSrcB    = SRCB_FOUR;
          ResultSrc  = RES_ALURESULT;
          pc_update  = 1'b1;
        end
        DECODE: begin
          ALUSrcA = SRCA_OLDPC;
          ALUSrcB = SRCB_IMM;
        end
        MEMADR: begin
          ALUSrcA = SRCA_REGA;
          ALUSrcB = SRCB_IMM;
        end
        MEMREAD:  AdrSrc = 1'b1;
        MEMWB: begin
          ResultSrc   = RES_DATA;
          reg_write_s = 1'b1;
        end
        MEMWRITE: begin
          AdrSrc      = 1'b1;
          mem_write_s = 1'b1;
        end
        EXECUTER: begin
          ALUSrcA = SRCA_REGA;
          alu_op  = ALUOP_FUNCT;
        end
        EXECUTEI: begin
          ALUSrcA = SRCA_REGA;
          ALUSrcB = SRCB_IMM;
          alu_op  = ALUOP_FUNCT;
        end
        ALUWB: reg_write_s = 1'b1;
        BEQ: begin
          ALUSrcA = SRCA_REGA;
          alu_op  = ALUOP_SUB;
          branch  = 1'b1;
        end
        JAL: begin
          ALUSrcA   = SRCA_OLDPC;
          ALUSrcB   = SRCB_FOUR;
          pc_update = 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef CTRL_BNE_EN
  always_comb begin
    case (funct3)
      3'b000:  taken = zero;
      3'b001:  taken = ~zero;
      default: taken = 1'b0;
    endcase
  end
`else
  assign taken = zero;
`endif

  assign PCWrite  = pc_update | (branch & taken);
  assign MemWrite = mem_write_s;
  assign IRWrite  = ir_write_s;
  assign RegWrite = reg_write_s;

  always_comb begin
    case (op)
      OP_STORE: ImmSrc = IMM_S;
      OP_BRNCH: ImmSrc = IMM_B;
      OP_JAL:   ImmSrc = IMM_J;
      default:  ImmSrc = IMM_I;
    endcase
  end

  alu_decoder u_alu_decoder (
    .ALUOp       (alu_op),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .op5         (op[5]),
    .ALU_control (ALU_control)
  );

endmodule

// File: tb/tb_control_unit.sv
// Directed per-cycle vector bench for control_unit, plus a reset-held sequence.
module tb_control_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] op = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic       funct7b5 = 1'b0;
  logic       zero = 1'b0;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALU_control;

  int n_vec = 0;
  int n_bad = 0;

`ifdef CTRL_BNE_EN
  localparam logic BNE = 1'b1;
`else
  localparam logic BNE = 1'b0;
`endif

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
  localparam logic [6:0] IT = 7'b0010011, JL = 7'b1101111, BR = 7'b1100011;
  localparam logic [6:0] BAD = 7'b0000000;

  control_unit dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5), .zero(zero),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ImmSrc(ImmSrc), .ALU_control(ALU_control)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic        z;
    logic [15:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[$];

  // {PCWrite,AdrSrc,MemWrite,IRWrite,RegWrite,ResultSrc,ALUSrcA,ALUSrcB,ImmSrc,ALU_control}
  function automatic logic [15:0] e(input logic pcw, adr, mw, irw, rw,
                                    input logic [1:0] rs, a, b, imm, input logic [2:0] alu);
    return {pcw, adr, mw, irw, rw, rs, a, b, imm, alu};
  endfunction

  function automatic logic [15:0] w_fetch(input logic [1:0] imm);
    return e(1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, imm, 3'b000);
  endfunction
  function automatic logic [15:0] w_decode(input logic [1:0] imm);
    return e(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, imm, 3'b000);
  endfunction
  function automatic logic [15:0] w_wb(input logic [1:0] imm);
    return e(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, imm, 3'b000);
  endfunction
  function automatic logic [15:0] w_rst(input logic [1:0] imm);
    return e(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, imm, 3'b000);
  endfunction

  task automatic add(input logic rst, input logic [6:0] o, input logic [2:0] f3,
                     input logic f7, input logic z, input logic [15:0] ex, input string nm);
    vec_t v;
    v.rst = rst; v.op = o; v.f3 = f3; v.f7 = f7; v.z = z; v.exp = ex; v.name = nm;
    vecs.push_back(v);
  endtask

  function automatic logic [15:0] actual();
    return {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB,
            ImmSrc, ALU_control};
  endfunction

  task automatic check(input string nm, input logic [15:0] ex);
    logic [15:0] act;
    act = actual();
    n_vec++;
    if (act !== ex) begin
      n_bad++;
      $display("FAIL %s: got %b want %b", nm, act, ex);
    end
  endtask

  task automatic step(input logic rst, input logic [6:0] o, input logic [2:0] f3,
                      input logic f7, input logic z);
    @(posedge clk);
    #1;
    reset = rst; op = o; funct3 = f3; funct7b5 = f7; zero = z;
  endtask

  initial begin
    add(1, RT, 3'b000, 0, 0, w_rst(2'b00), "reset");
    // add x3,x1,x2
    add(0, RT, 3'b000, 0, 0, w_fetch(2'b00), "add_fetch");
    add(0, RT, 3'b000, 0, 0, w_decode(2'b00), "add_decode");
    add(0, RT, 3'b000, 0, 0, e(0,0,0,0,0,2'b00,2'b10,2'b00,2'b00,3'b000), "add_exer");
    add(0, RT, 3'b000, 0, 0, w_wb(2'b00), "add_aluwb");
    // sub
    add(0, RT, 3'b000, 1, 0, w_fetch(2'b00), "sub_fetch");
    add(0, RT, 3'b000, 1, 0, w_decode(2'b00), "sub_decode");
    add(0, RT, 3'b000, 1, 0, e(0,0,0,0,0,2'b00,2'b10,2'b00,2'b00,3'b001), "sub_exer");
    add(0, RT, 3'b000, 1, 0, w_wb(2'b00), "sub_aluwb");
    // addi with funct7b5=1 still adds
    add(0, IT, 3'b000, 1, 0, w_fetch(2'b00), "addi_fetch");
    add(0, IT, 3'b000, 1, 0, w_decode(2'b00), "addi_decode");
    add(0, IT, 3'b000, 1, 0, e(0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,3'b000), "addi_exei");
    add(0, IT, 3'b000, 1, 0, w_wb(2'b00), "addi_aluwb");
    // lw
    add(0, LW, 3'b010, 0, 0, w_fetch(2'b00), "lw_fetch");
    add(0, LW, 3'b010, 0, 0, w_decode(2'b00), "lw_decode");
    add(0, LW, 3'b010, 0, 0, e(0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,3'b000), "lw_memadr");
    add(0, LW, 3'b010, 0, 0, e(0,1,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000), "lw_memread");
    add(0, LW, 3'b010, 0, 0, e(0,0,0,0,1,2'b01,2'b00,2'b00,2'b00,3'b000), "lw_memwb");
    // sw
    add(0, SW, 3'b010, 0, 0, w_fetch(2'b01), "sw_fetch");
    add(0, SW, 3'b010, 0, 0, w_decode(2'b01), "sw_decode");
    add(0, SW, 3'b010, 0, 0, e(0,0,0,0,0,2'b00,2'b10,2'b01,2'b01,3'b000), "sw_memadr");
    add(0, SW, 3'b010, 0, 0, e(0,1,1,0,0,2'b00,2'b00,2'b00,2'b01,3'b000), "sw_memwrite");
    // beq taken / not taken
    add(0, BR, 3'b000, 0, 1, w_fetch(2'b10), "beq_t_fetch");
    add(0, BR, 3'b000, 0, 1, w_decode(2'b10), "beq_t_decode");
    add(0, BR, 3'b000, 0, 1, e(1,0,0,0,0,2'b00,2'b10,2'b00,2'b10,3'b001), "beq_t_beq");
    add(0, BR, 3'b000, 0, 0, w_fetch(2'b10), "beq_n_fetch");
    add(0, BR, 3'b000, 0, 0, w_decode(2'b10), "beq_n_decode");
    add(0, BR, 3'b000, 0, 0, e(0,0,0,0,0,2'b00,2'b10,2'b00,2'b10,3'b001), "beq_n_beq");
    // bne encoding with zero=0: taken only when the bne extension is built in
    add(0, BR, 3'b001, 0, 0, w_fetch(2'b10), "bne_fetch");
    add(0, BR, 3'b001, 0, 0, w_decode(2'b10), "bne_decode");
    add(0, BR, 3'b001, 0, 0, e(BNE,0,0,0,0,2'b00,2'b10,2'b00,2'b10,3'b001), "bne_beq");
    // jal
    add(0, JL, 3'b000, 0, 0, w_fetch(2'b11), "jal_fetch");
    add(0, JL, 3'b000, 0, 0, w_decode(2'b11), "jal_decode");
    add(0, JL, 3'b000, 0, 0, e(1,0,0,0,0,2'b00,2'b01,2'b10,2'b11,3'b000), "jal_jal");
    add(0, JL, 3'b000, 0, 0, w_wb(2'b11), "jal_aluwb");
    // illegal opcode falls back to FETCH
    add(0, BAD, 3'b000, 0, 1, w_fetch(2'b00), "bad_fetch");
    add(0, BAD, 3'b000, 0, 1, w_decode(2'b00), "bad_decode");
    add(0, BAD, 3'b000, 0, 1, w_fetch(2'b00), "bad_refetch");
    add(0, BAD, 3'b000, 0, 1, w_decode(2'b00), "bad_redecode");
    // or / and / slt
    add(0, RT, 3'b110, 0, 0, w_fetch(2'b00), "or_fetch");
    add(0, RT, 3'b110, 0, 0, w_decode(2'b00), "or_decode");
    add(0, RT, 3'b110, 0, 0, e(0,0,0,0,0,2'b00,2'b10,2'b00,2'b00,3'b011), "or_exer");
    add(0, RT, 3'b110, 0, 0, w_wb(2'b00), "or_aluwb");
    add(0, RT, 3'b111, 0, 0, w_fetch(2'b00), "and_fetch");
    add(0, RT, 3'b111, 0, 0, w_decode(2'b00), "and_decode");
    add(0, RT, 3'b111, 0, 0, e(0,0,0,0,0,2'b00,2'b10,2'b00,2'b00,3'b010), "and_exer");
    add(0, RT, 3'b111, 0, 0, w_wb(2'b00), "and_aluwb");
    add(0, IT, 3'b010, 0, 0, w_fetch(2'b00), "slti_fetch");
    add(0, IT, 3'b010, 0, 0, w_decode(2'b00), "slti_decode");
    add(0, IT, 3'b010, 0, 0, e(0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,3'b101), "slti_exei");
    add(0, IT, 3'b010, 0, 0, w_wb(2'b00), "slti_aluwb");
    // reset asserted while in MEMWRITE
    add(0, SW, 3'b010, 0, 0, w_fetch(2'b01), "rsw_fetch");
    add(0, SW, 3'b010, 0, 0, w_decode(2'b01), "rsw_decode");
    add(0, SW, 3'b010, 0, 0, e(0,0,0,0,0,2'b00,2'b10,2'b01,2'b01,3'b000), "rsw_memadr");
    add(1, SW, 3'b010, 0, 0, w_rst(2'b01), "rsw_memwrite_rst");
    add(0, SW, 3'b010, 0, 0, w_fetch(2'b01), "rsw_after_fetch");
    add(0, SW, 3'b010, 0, 0, w_decode(2'b01), "rsw_after_decode");

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].op, vecs[i].f3, vecs[i].f7, vecs[i].z);
      @(negedge clk);
      check(vecs[i].name, vecs[i].exp);
    end

    // Reset held for two cycles starting in MEMADR, then release into FETCH
    step(0, LW, 3'b000, 0, 0);
    @(negedge clk);
    check("hold_memadr", e(0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,3'b000));
    step(1, LW, 3'b000, 0, 0);
    @(negedge clk);
    check("hold_rst1", w_rst(2'b00));
    step(1, JL, 3'b000, 0, 1);
    @(negedge clk);
    check("hold_rst2", w_rst(2'b11));
    step(0, JL, 3'b000, 0, 1);
    @(negedge clk);
    check("hold_release_fetch", w_fetch(2'b11));
    step(0, JL, 3'b000, 0, 1);
    @(negedge clk);
    check("hold_release_decode", w_decode(2'b11));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
